// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted conditional branches awaiting resolution by execute.
// Emits a registered predictor update per resolve, and redirect + BHR repair on a mispredict.
module branch_resolution_queue #(
  parameter int DEPTH     = 4,
  parameter int IDX_WIDTH = 4,
  parameter int BHR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [31:0]                  enq_pc,
  input  logic [IDX_WIDTH-1:0]         enq_pht_idx,
  input  logic [BHR_WIDTH-1:0]         enq_bhr,
  input  logic                         enq_pred_taken,
  input  logic [31:0]                  enq_pred_target,
  input  logic                         res_valid,
  input  logic                         res_taken,
  input  logic [31:0]                  res_target,
  output logic                         upd_valid,
  output logic                         upd_taken,
  output logic [IDX_WIDTH-1:0]         upd_pht_idx,
  output logic [31:0]                  upd_pc,
  output logic                         mispredict,
  output logic [31:0]                  redirect_pc,
  output logic [BHR_WIDTH-1:0]         recover_bhr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         res_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {S_RUN, S_RECOVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;

  logic [31:0]          r_pc_mem   [DEPTH];
  logic [IDX_WIDTH-1:0] r_idx_mem  [DEPTH];
  logic [BHR_WIDTH-1:0] r_bhr_mem  [DEPTH];
  logic                 r_ptk_mem  [DEPTH];
  logic [31:0]          r_tgt_mem  [DEPTH];

  logic [31:0]          w_head_pc;
  logic [IDX_WIDTH-1:0] w_head_idx;
  logic [BHR_WIDTH-1:0] w_head_bhr;
  logic                 w_head_ptk;
  logic [31:0]          w_head_tgt;
  logic                 w_full;
  logic                 w_res_fire;
  logic                 w_mis_fire;
  logic                 w_enq_fire;

  // A target mismatch only matters when the branch was actually taken.
  function automatic logic f_mispredict(input logic act_tk, input logic [31:0] act_tgt,
                                        input logic pred_tk, input logic [31:0] pred_tgt);
    return (act_tk != pred_tk) || (act_tk && (act_tgt != pred_tgt));
  endfunction

  function automatic logic [31:0] f_redirect(input logic act_tk, input logic [31:0] act_tgt,
                                             input logic [31:0] br_pc);
    return act_tk ? act_tgt : (br_pc + 32'd4);
  endfunction

  function automatic logic [BHR_WIDTH-1:0] f_repair_bhr(input logic [BHR_WIDTH-1:0] snap,
                                                        input logic act_tk);
    return (snap << 1) | BHR_WIDTH'(act_tk);
  endfunction

  assign w_head_pc  = r_pc_mem[r_head];
  assign w_head_idx = r_idx_mem[r_head];
  assign w_head_bhr = r_bhr_mem[r_head];
  assign w_head_ptk = r_ptk_mem[r_head];
  assign w_head_tgt = r_tgt_mem[r_head];

  assign w_full     = (r_count == CW'(DEPTH));
  assign enq_ready  = (r_state == S_RUN) && !w_full;
  assign count      = r_count;

  assign w_res_fire = res_valid && (r_state == S_RUN) && (r_count != '0);
  assign w_mis_fire = w_res_fire &&
                      f_mispredict(res_taken, res_target, w_head_ptk, w_head_tgt);
  // A mispredict squashes anything fetch offers in the same cycle.
  assign w_enq_fire = enq_valid && enq_ready && !w_mis_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    case (r_state)
      S_RUN: begin
        if (w_mis_fire) begin
          w_head_nxt  = r_head + PW'(1);
          w_tail_nxt  = r_head + PW'(1);
          w_count_nxt = '0;
          w_state_nxt = S_RECOVER;
        end else begin
          if (w_res_fire) w_head_nxt = r_head + PW'(1);
          if (w_enq_fire) w_tail_nxt = r_tail + PW'(1);
          w_count_nxt = r_count + CW'(w_enq_fire) - CW'(w_res_fire);
        end
      end
      S_RECOVER: w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc_mem[r_tail]  <= enq_pc;
      r_idx_mem[r_tail] <= enq_pht_idx;
      r_bhr_mem[r_tail] <= enq_bhr;
      r_ptk_mem[r_tail] <= enq_pred_taken;
      r_tgt_mem[r_tail] <= enq_pred_target;
    end
  end

  // Result stage: one-cycle pulses plus payloads held until the next resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pht_idx <= '0;
      upd_pc      <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      recover_bhr <= '0;
      res_error   <= 1'b0;
    end else begin
      upd_valid  <= w_res_fire;
      mispredict <= w_mis_fire;
      res_error  <= res_valid && !w_res_fire;
      if (w_res_fire) begin
        upd_taken   <= res_taken;
        upd_pht_idx <= w_head_idx;
        upd_pc      <= w_head_pc;
      end
      if (w_mis_fire) begin
        redirect_pc <= f_redirect(res_taken, res_target, w_head_pc);
        recover_bhr <= f_repair_bhr(w_head_bhr, res_taken);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_branch_resolution_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready;
  logic [31:0] enq_pc;
  logic [3:0]  enq_pht_idx, enq_bhr;
  logic        enq_pred_taken;
  logic [31:0] enq_pred_target;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken;
  logic [3:0]  upd_pht_idx;
  logic [31:0] upd_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  recover_bhr;
  logic [2:0]  count;
  logic        res_error;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  branch_resolution_queue #(.DEPTH(DEPTH), .IDX_WIDTH(4), .BHR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pht_idx(enq_pht_idx), .enq_bhr(enq_bhr), .enq_pred_taken(enq_pred_taken),
    .enq_pred_target(enq_pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pht_idx(upd_pht_idx), .upd_pc(upd_pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .recover_bhr(recover_bhr),
    .count(count), .res_error(res_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  idx;
    logic [3:0]  bhr;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_h;
  logic        m_rec = 1'b0, m_rdy, m_mis;
  logic        e_uv = 1'b0, e_mis = 1'b0, e_err = 1'b0, e_tk = 1'b0;
  logic [3:0]  e_idx = '0, e_rbhr = '0;
  logic [31:0] e_pc = '0, e_rpc = '0;

  // Reference model: program-order queue of predictions.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rec = 1'b0; e_uv = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_tk = 1'b0;
      e_idx = '0; e_pc = '0; e_rpc = '0; e_rbhr = '0;
    end else begin
      m_rdy = !m_rec && (mq.size() < DEPTH);
      m_mis = 1'b0;
      e_uv = 1'b0; e_mis = 1'b0; e_err = 1'b0;
      if (res_valid) begin
        if (m_rec || mq.size() == 0) begin
          e_err = 1'b1;
        end else begin
          m_h = mq.pop_front();
          e_uv = 1'b1; e_tk = res_taken; e_idx = m_h.idx; e_pc = m_h.pc;
          m_mis = (res_taken != m_h.pt) || (res_taken && res_target != m_h.tgt);
          if (m_mis) begin
            e_mis  = 1'b1;
            e_rpc  = res_taken ? res_target : m_h.pc + 32'd4;
            e_rbhr = {m_h.bhr[2:0], res_taken};
            mq.delete();
          end
        end
      end
      if (enq_valid && m_rdy && !m_mis)
        mq.push_back('{pc: enq_pc, idx: enq_pht_idx, bhr: enq_bhr,
                       pt: enq_pred_taken, tgt: enq_pred_target});
      m_rec = m_mis;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.enq_ready", {31'd0, enq_ready}, {31'd0, (!m_rec && mq.size() < DEPTH)});
      chk("m.count", {29'd0, count}, mq.size());
      chk("m.upd_valid", {31'd0, upd_valid}, {31'd0, e_uv});
      chk("m.mispredict", {31'd0, mispredict}, {31'd0, e_mis});
      chk("m.res_error", {31'd0, res_error}, {31'd0, e_err});
      if (e_uv) begin
        chk("m.upd_taken", {31'd0, upd_taken}, {31'd0, e_tk});
        chk("m.upd_pht_idx", {28'd0, upd_pht_idx}, {28'd0, e_idx});
        chk("m.upd_pc", upd_pc, e_pc);
      end
      if (e_mis) begin
        chk("m.redirect_pc", redirect_pc, e_rpc);
        chk("m.recover_bhr", {28'd0, recover_bhr}, {28'd0, e_rbhr});
      end
    end
  end

  task automatic drive(input logic ev, input logic [31:0] pc, input logic [3:0] idx,
                       input logic [3:0] bhr, input logic pt, input logic [31:0] tgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    enq_valid = ev; enq_pc = pc; enq_pht_idx = idx; enq_bhr = bhr;
    enq_pred_taken = pt; enq_pred_target = tgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    @(posedge clk); #1;
    enq_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [3:0] idx, input logic [3:0] bhr,
                     input logic pt, input logic [31:0] tgt);
    drive(1'b1, pc, idx, bhr, pt, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic res(input logic rt, input logic [31:0] rtgt);
    drive(1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b1, rt, rtgt);
  endtask

  logic [31:0] nxt_pc, exp_pc;

  initial begin
    rst = 1'b1;
    enq_valid = 0; enq_pc = 0; enq_pht_idx = 0; enq_bhr = 0;
    enq_pred_taken = 0; enq_pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst.count", {29'd0, count}, 32'd0);
    chk("rst.enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst.upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);

    // Correct taken prediction
    enq(32'h100, 4'd3, 4'b0101, 1'b1, 32'h200);
    chk("t1.count_after_enq", {29'd0, count}, 32'd1);
    res(1'b1, 32'h200);
    chk("t1.upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t1.upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t1.upd_pht_idx", {28'd0, upd_pht_idx}, 32'd3);
    chk("t1.upd_pc", upd_pc, 32'h100);
    chk("t1.mispredict", {31'd0, mispredict}, 32'd0);
    chk("t1.count", {29'd0, count}, 32'd0);

    // Direction mispredict with younger entries flushed, then resolve during RECOVER
    enq(32'h40, 4'd1, 4'b0011, 1'b1, 32'h80);
    enq(32'h50, 4'd2, 4'b0000, 1'b0, 32'h0);
    enq(32'h60, 4'd4, 4'b0001, 1'b1, 32'h90);
    chk("t2.count3", {29'd0, count}, 32'd3);
    res(1'b0, 32'h0);
    chk("t2.mispredict", {31'd0, mispredict}, 32'd1);
    chk("t2.redirect_pc", redirect_pc, 32'h44);
    chk("t2.recover_bhr", {28'd0, recover_bhr}, 32'b0110);
    chk("t2.count", {29'd0, count}, 32'd0);
    chk("t2.enq_ready_recover", {31'd0, enq_ready}, 32'd0);
    res(1'b1, 32'h999);
    chk("t2.res_error_recover", {31'd0, res_error}, 32'd1);
    chk("t2.upd_valid_recover", {31'd0, upd_valid}, 32'd0);
    chk("t2.enq_ready_back", {31'd0, enq_ready}, 32'd1);

    // Resolve with empty queue
    res(1'b0, 32'h0);
    chk("t5.res_error_empty", {31'd0, res_error}, 32'd1);
    chk("t5.upd_valid_empty", {31'd0, upd_valid}, 32'd0);
    chk("t5.count_empty", {29'd0, count}, 32'd0);

    // Full queue: enqueue+resolve together rejects the enqueue; repeat for pointer wrap
    nxt_pc = 32'h1000; exp_pc = 32'h1000;
    for (int i = 0; i < DEPTH; i++) begin
      enq(nxt_pc, nxt_pc[5:2], 4'd0, 1'b0, 32'd0);
      nxt_pc += 32'd4;
    end
    chk("t3.enq_ready_full", {31'd0, enq_ready}, 32'd0);
    chk("t3.count_full", {29'd0, count}, 32'd4);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'hDEAD0000, 4'hF, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk("t3.fifo_upd_pc", upd_pc, exp_pc);
      exp_pc += 32'd4;
      chk("t3.count_after_reject", {29'd0, count}, 32'd3);
      chk("t3.enq_ready_after", {31'd0, enq_ready}, 32'd1);
      enq(nxt_pc, nxt_pc[5:2], 4'd0, 1'b0, 32'd0);
      nxt_pc += 32'd4;
    end
    for (int i = 0; i < DEPTH; i++) begin
      res(1'b0, 32'd0);
      chk("t3.drain_upd_pc", upd_pc, exp_pc);
      exp_pc += 32'd4;
    end
    chk("t3.drained", {29'd0, count}, 32'd0);

    // Target mispredict with same-cycle enqueue dropped
    enq(32'h10, 4'd5, 4'b1001, 1'b1, 32'h300);
    drive(1'b1, 32'h20, 4'd6, 4'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h380);
    chk("t4.mispredict", {31'd0, mispredict}, 32'd1);
    chk("t4.redirect_pc", redirect_pc, 32'h380);
    chk("t4.recover_bhr", {28'd0, recover_bhr}, 32'b0011);
    chk("t4.count", {29'd0, count}, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t4.count_idle", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-burst
    enq(32'h500, 4'd1, 4'd0, 1'b0, 32'd0);
    enq(32'h504, 4'd2, 4'd0, 1'b0, 32'd0);
    enq(32'h508, 4'd3, 4'd0, 1'b0, 32'd0);
    res(1'b0, 32'd0);
    chk("t6.count2", {29'd0, count}, 32'd2);
    chk("t6.upd_pc_pre", upd_pc, 32'h500);
    #3 rst = 1'b1;
    #1;
    chk("t6.upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t6.upd_pc", upd_pc, 32'd0);
    chk("t6.upd_pht_idx", {28'd0, upd_pht_idx}, 32'd0);
    chk("t6.count", {29'd0, count}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("t6.enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("t6.head", {30'd0, dut.r_head}, 32'd0);
    chk("t6.tail", {30'd0, dut.r_tail}, 32'd0);
    enq(32'h700, 4'd7, 4'd0, 1'b0, 32'd0);
    chk("t6.slot0", dut.r_pc_mem[0], 32'h700);
    res(1'b0, 32'd0);
    chk("t6.first_upd_pc", upd_pc, 32'h700);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
